// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with redirect handling, req/ack imem handshake and IF/ID register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h00000000,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_d,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pcplus4_d,
    output logic        valid_d
);
    typedef enum logic [1:0] {FETCH, KILL, HOLD} state_t;
    state_t      state_q, state_d;
    logic [31:0] fpc_q, fpc_d, pend_q, pend_d, bi_q, bi_d, bp_q, bp_d;
    logic [31:0] id_instr_q, id_instr_d, id_pc_q, id_pc_d, id_pc4_q, id_pc4_d;
    logic        id_valid_q, id_valid_d;
    logic        wv;
    logic [31:0] wi, wp, rpc;
    assign rpc       = redirect_pc & ~32'h3;
    assign imem_req  = !rst && state_q != HOLD;
    assign imem_addr = fpc_q;
    assign instr_d   = id_instr_q;
    assign pc_d      = id_pc_q;
    assign pcplus4_d = id_pc4_q;
    assign valid_d   = id_valid_q;
    always_comb begin
        state_d = state_q;
        fpc_d   = fpc_q;
        pend_d  = pend_q;
        bi_d    = bi_q;
        bp_d    = bp_q;
        wv      = 1'b0;
        wi      = bi_q;
        wp      = bp_q;
        case (state_q)
            FETCH: begin
                if (redirect) begin
                    if (imem_ack) fpc_d = rpc;
                    else begin
                        pend_d  = rpc;
                        state_d = KILL;
                    end
                end else if (imem_ack) begin
                    fpc_d = fpc_q + 32'd4;
                    if (stall_d) begin
                        bi_d    = imem_rdata;
                        bp_d    = fpc_q;
                        state_d = HOLD;
                    end else begin
                        wv = 1'b1;
                        wi = imem_rdata;
                        wp = fpc_q;
                    end
                end
            end
            // imem_addr stays on the abandoned pc until its response drains
            KILL: begin
                if (redirect) pend_d = rpc;
                if (imem_ack) begin
                    fpc_d   = redirect ? rpc : pend_q;
                    state_d = FETCH;
                end
            end
            HOLD: begin
                if (redirect) begin
                    fpc_d   = rpc;
                    state_d = FETCH;
                end else if (!stall_d) begin
                    wv      = 1'b1;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
        id_valid_d = redirect ? 1'b0 : stall_d ? id_valid_q : wv;
        id_instr_d = redirect ? NOP_INSTR : stall_d ? id_instr_q : wv ? wi : NOP_INSTR;
        id_pc_d    = (!redirect && !stall_d && wv) ? wp : id_pc_q;
        id_pc4_d   = (!redirect && !stall_d && wv) ? wp + 32'd4 : id_pc4_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FETCH;
            fpc_q      <= RESET_PC & ~32'h3;
            pend_q     <= '0;
            bi_q       <= '0;
            bp_q       <= '0;
            id_instr_q <= NOP_INSTR;
            id_pc_q    <= '0;
            id_pc4_q   <= '0;
            id_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fpc_q      <= fpc_d;
            pend_q     <= pend_d;
            bi_q       <= bi_d;
            bp_q       <= bp_d;
            id_instr_q <= id_instr_d;
            id_pc_q    <= id_pc_d;
            id_pc4_q   <= id_pc4_d;
            id_valid_q <= id_valid_d;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vector table plus hand sequences for fetch_stage.
module tb_fetch_stage;
    localparam logic [31:0] K   = 32'hA5A5A5A5;
    localparam logic [31:0] NOP = 32'h00000013;
    typedef struct {
        logic        s;
        logic        r;
        logic [31:0] rpc;
        int          lat;
        logic        v;
        logic [31:0] pc;
        logic        req;
        logic [31:0] addr;
    } vec_t;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_d = 1'b0, redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        req0, ack0, valid0, req1, valid1;
    logic [31:0] addr0, rdata0, instr0, pc0, pc40, addr1, instr1, pc1, pc41;
    int          lat = 0, cnt = 0, total = 0, bad = 0;
    vec_t        q[$];
    fetch_stage u0 (
        .clk(clk), .rst(rst), .stall_d(stall_d), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(req0), .imem_addr(addr0), .imem_ack(ack0), .imem_rdata(rdata0),
        .instr_d(instr0), .pc_d(pc0), .pcplus4_d(pc40), .valid_d(valid0)
    );
    fetch_stage #(.RESET_PC(32'hFFFFFFFC)) u1 (
        .clk(clk), .rst(rst), .stall_d(1'b0), .redirect(1'b0), .redirect_pc(32'h0),
        .imem_req(req1), .imem_addr(addr1), .imem_ack(req1), .imem_rdata(addr1 ^ K),
        .instr_d(instr1), .pc_d(pc1), .pcplus4_d(pc41), .valid_d(valid1)
    );
    always #5 clk = ~clk;
    // Variable-latency memory: ack on the (lat+1)-th cycle of a held request
    assign ack0   = req0 && cnt == lat;
    assign rdata0 = addr0 ^ K;
    always @(posedge clk) cnt <= (rst || !req0 || ack0) ? 0 : cnt + 1;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    function automatic vec_t mk(logic s, logic r, logic [31:0] rpc, int l, logic v, logic [31:0] pc,
                                logic rq, logic [31:0] a);
        vec_t t;
        t.s = s; t.r = r; t.rpc = rpc; t.lat = l; t.v = v; t.pc = pc; t.req = rq; t.addr = a;
        return t;
    endfunction
    initial begin
        q.push_back(mk(0, 0, 0, 0, 1, 32'h0, 1, 32'h4));
        q.push_back(mk(0, 0, 0, 0, 1, 32'h4, 1, 32'h8));
        q.push_back(mk(0, 0, 0, 0, 1, 32'h8, 1, 32'hC));
        q.push_back(mk(0, 1, 32'h0, 0, 0, 0, 1, 32'h0));
        q.push_back(mk(0, 0, 0, 0, 1, 32'h0, 1, 32'h4));
        q.push_back(mk(0, 0, 0, 0, 1, 32'h4, 1, 32'h8));
        q.push_back(mk(1, 0, 0, 0, 1, 32'h4, 0, 0));
        q.push_back(mk(1, 0, 0, 0, 1, 32'h4, 0, 0));
        q.push_back(mk(1, 0, 0, 0, 1, 32'h4, 0, 0));
        q.push_back(mk(0, 0, 0, 0, 1, 32'h8, 1, 32'hC));
        q.push_back(mk(0, 0, 0, 0, 1, 32'hC, 1, 32'h10));
        q.push_back(mk(1, 1, 32'h103, 0, 0, 0, 1, 32'h100));
        q.push_back(mk(0, 0, 0, 0, 1, 32'h100, 1, 32'h104));
        q.push_back(mk(0, 0, 0, 2, 0, 0, 1, 32'h104));
        q.push_back(mk(0, 0, 0, 2, 0, 0, 1, 32'h104));
        q.push_back(mk(0, 0, 0, 2, 1, 32'h104, 1, 32'h108));
        q.push_back(mk(0, 0, 0, 2, 0, 0, 1, 32'h108));
        q.push_back(mk(0, 0, 0, 2, 0, 0, 1, 32'h108));
        q.push_back(mk(0, 0, 0, 2, 1, 32'h108, 1, 32'h10C));
        q.push_back(mk(0, 1, 32'h10, 2, 0, 0, 1, 32'h10C));
        q.push_back(mk(0, 0, 0, 2, 0, 0, 1, 32'h10C));
        q.push_back(mk(0, 0, 0, 2, 0, 0, 1, 32'h10));
        q.push_back(mk(0, 1, 32'h100, 2, 0, 0, 1, 32'h10));
        q.push_back(mk(0, 0, 0, 2, 0, 0, 1, 32'h10));
        q.push_back(mk(0, 0, 0, 2, 0, 0, 1, 32'h100));
        q.push_back(mk(0, 0, 0, 2, 0, 0, 1, 32'h100));
        q.push_back(mk(0, 0, 0, 2, 0, 0, 1, 32'h100));
        q.push_back(mk(0, 0, 0, 2, 1, 32'h100, 1, 32'h104));
        repeat (2) tick();
        chk("rst_req", {31'b0, req0}, 0);
        chk("rst_valid", {31'b0, valid0}, 0);
        chk("rst_instr", instr0, NOP);
        chk("rst_pc", pc0, 0);
        chk("rst_pc4", pc40, 0);
        rst = 1'b0;
        #1;
        chk("rel_req", {31'b0, req0}, 1);
        chk("rel_addr", addr0, 0);
        chk("wrap_addr0", addr1, 32'hFFFFFFFC);
        foreach (q[i]) begin
            stall_d = q[i].s;
            redirect = q[i].r;
            redirect_pc = q[i].rpc;
            lat = q[i].lat;
            tick();
            chk($sformatf("v%0d_valid", i), {31'b0, valid0}, {31'b0, q[i].v});
            chk($sformatf("v%0d_instr", i), instr0, q[i].v ? q[i].pc ^ K : NOP);
            if (q[i].v) begin
                chk($sformatf("v%0d_pc", i), pc0, q[i].pc);
                chk($sformatf("v%0d_pc4", i), pc40, q[i].pc + 32'd4);
            end
            chk($sformatf("v%0d_req", i), {31'b0, req0}, {31'b0, q[i].req});
            if (q[i].req) chk($sformatf("v%0d_addr", i), addr0, q[i].addr);
            if (i == 0) begin
                chk("wrap_pc", pc1, 32'hFFFFFFFC);
                chk("wrap_pc4", pc41, 0);
                chk("wrap_addr1", addr1, 0);
            end
        end
        stall_d = 1'b0;
        redirect = 1'b0;
        lat = 2;
        tick();
        chk("wait_addr", addr0, 32'h104);
        rst = 1'b1;
        #1;
        chk("mid_req", {31'b0, req0}, 0);
        chk("mid_valid", {31'b0, valid0}, 0);
        chk("mid_instr", instr0, NOP);
        chk("mid_pc", pc0, 0);
        chk("mid_pc4", pc40, 0);
        chk("mid_u1_pc", pc1, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("rel2_req", {31'b0, req0}, 1);
        chk("rel2_addr", addr0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage with the IF/ID pipeline register. It feeds the decode stage, where the immediate generator and control decode consume `instr_d`.
- Owns the fetch PC and handles redirects from branches and jumps.
- Talks to instruction memory over a req/ack handshake with variable latency.
- Holds or bubbles the IF/ID register under decode stall and flush.

Parameters:
- RESET_PC, 32'h00000000, fetch address after reset; bits [1:0] must be 0.
- NOP_INSTR, 32'h00000013, instruction word inserted on bubbles (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- stall_d  in  1  decode cannot accept; hold the IF/ID register.
- redirect  in  1  taken branch or jump; flush and refetch.
- redirect_pc  in  32  redirect target; bits [1:0] are ignored and treated as 0.
- imem_req  out  1  fetch request, level.
- imem_addr  out  32  fetch address; bits [1:0] are always 0.
- imem_ack  in  1  response valid; the transfer completes on a cycle with req&&ack.
- imem_rdata  in  32  instruction word; valid when ack is high.
- instr_d  out  32  IF/ID instruction.
- pc_d  out  32  IF/ID PC.
- pcplus4_d  out  32  IF/ID PC+4.
- valid_d  out  1  IF/ID holds a real instruction.

Behaviour:
- **Reset** (async, on rst high):
  - pc_f=RESET_PC, state=FETCH, pend_pc=0, buffer cleared.
  - instr_d=NOP_INSTR, pc_d=0, pcplus4_d=0, valid_d=0.
  - imem_req=0 while rst is high; it rises on the first cycle after reset deasserts.
  - Reset mid-request abandons the request; the memory is reset together with this block.
- **Handshake:**
  - imem_req and imem_addr are held stable from assertion until the ack cycle. Only one request is ever outstanding.
  - A zero-wait memory (ack in the same cycle as req) gives 1 instruction per cycle.
  - The instruction appears on instr_d the cycle after ack.
- **Arithmetic:** PC increment is pc+4, modulo 2^32; 32'hFFFFFFFC wraps to 0.
- **IF/ID update priority:** rst > redirect > stall_d > load.
  - redirect: IF/ID <= bubble (NOP_INSTR, valid_d=0) even if stall_d is high.
  - stall_d: IF/ID holds.
  - Otherwise IF/ID is loaded with a fetched word, or with a bubble when no word is available.
- **State FETCH** (imem_req=1, imem_addr=pc_f):
  - ack & redirect: discard rdata; pc_f<=redirect_pc; stay in FETCH.
  - !ack & redirect: pend_pc<=redirect_pc; go to KILL. imem_addr stays at the old pc_f.
  - ack & !redirect & !stall_d: IF/ID<={rdata, pc_f, pc_f+4, valid=1}; pc_f<=pc_f+4.
  - ack & !redirect & stall_d: buffer<={rdata, pc_f}; pc_f<=pc_f+4; go to HOLD.
  - !ack & !redirect: IF/ID bubbles if !stall_d, else holds.
- **State KILL** (imem_req=1, imem_addr=old pc_f; waiting to drain a discarded response):
  - A further redirect overwrites pend_pc; the latest target wins.
  - On ack: discard rdata; pc_f<=pend_pc, or redirect_pc if redirect is high that cycle; go to FETCH.
  - IF/ID bubbles if !stall_d, else holds.
- **State HOLD** (imem_req=0, one buffered word):
  - redirect: drop the buffer; pc_f<=redirect_pc; go to FETCH.
  - !stall_d: IF/ID<={buf_instr, buf_pc, buf_pc+4, valid=1}; go to FETCH. The request is reissued the next cycle.
  - stall_d: remain in HOLD.
- **Invariants:**
  - No instruction is lost or duplicated under any stall pattern.
  - No word is delivered from an address fetched before a redirect.
  - valid_d=0 always implies instr_d=NOP_INSTR.

Test Plan:
- Reset, zero-wait memory (ack=req, rdata=addr^32'hA5A5A5A5), run 4 cycles -> pc_d=0,4,8 on consecutive cycles; valid_d=1 from the 2nd cycle; instr_d matches.
- Memory with 2-cycle ack latency -> imem_addr is held stable until ack; valid_d=0 with NOP on non-ack cycles; instructions are delivered in order at one per 3 cycles.
- stall_d high for 3 cycles while ack arrives at pc 0x8 -> IF/ID frozen; state HOLD with imem_req=0. After release, pc_d=0x8 appears once and the next fetch is 0xC.
- redirect to 0x100 while a request to 0x10 is outstanding (ack 2 cycles later) -> the word from 0x10 is discarded; next imem_addr=0x100; IF/ID bubble on the redirect cycle.
- redirect and stall_d high together -> valid_d=0 and instr_d=32'h13 next cycle; the fetch resumes at the target. redirect_pc=0x103 is fetched as 0x100.
- RESET_PC=32'hFFFFFFFC -> the second fetch address is 0x0 and pcplus4_d=0. Assert rst mid-WAIT -> all outputs return to reset values immediately.
